// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-select decoder for the 32x64 register file.
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_WIDTH  = 64;
  localparam int ADDR_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd31;

  typedef logic [REG_WIDTH-1:0]  regWord_t;
  typedef logic [ADDR_WIDTH-1:0] regAddr_t;

  // One select per physical cell; the zero register has no cell, so its index never decodes.
  function automatic logic [NUM_REGS-2:0] decodeWrite(input regAddr_t addr, input logic en);
    logic [NUM_REGS-2:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_REGS-1; i++) begin
      sel[i] = en && (addr == ADDR_WIDTH'(i));
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_reg64.sv
// Single 64-bit storage cell with asynchronous active-high clear and write enable.
module regfile_reg64
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wrEn,
  input  logic [REG_WIDTH-1:0] d,
  output logic [REG_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (wrEn) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile.sv
// 32x64 register file, two combinational read ports, one write port, X31 reads as zero.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module regfile
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readReg0,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [REG_WIDTH-1:0]  writeData,
  input  logic                  regWrEn,
  output logic [REG_WIDTH-1:0]  readData0,
  output logic [REG_WIDTH-1:0]  readData1
);

  logic [NUM_REGS-2:0] wrSel;
  regWord_t            cellQ   [NUM_REGS-1];
  regWord_t            regView [NUM_REGS];
  regWord_t            rawRead0;
  regWord_t            rawRead1;

  assign wrSel = decodeWrite(writeReg, regWrEn);

  for (genvar g = 0; g < NUM_REGS-1; g++) begin : gCell
    regfile_reg64 uCell (
      .clk   (clk),
      .reset (reset),
      .wrEn  (wrSel[g]),
      .d     (writeData),
      .q     (cellQ[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS-1; i++) begin
      regView[i] = cellQ[i];
    end
    regView[NUM_REGS-1] = '0;
  end

  always_comb begin
    rawRead0 = regView[readReg0];
    rawRead1 = regView[readReg1];
`ifdef REGFILE_BYPASS_EN
    if (regWrEn && (writeReg != ZERO_REG) && (readReg0 == writeReg)) rawRead0 = writeData;
    if (regWrEn && (writeReg != ZERO_REG) && (readReg1 == writeReg)) rawRead1 = writeData;
`else
    rawRead0 = rawRead0;
    rawRead1 = rawRead1;
`endif
    // Reset masks the ports so forwarded data cannot leak out while clearing.
    readData0 = reset ? '0 : rawRead0;
    readData1 = reset ? '0 : rawRead1;
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboarded random/directed bench for regfile against an array-based reference model.
module tb_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  readReg0, readReg1, writeReg;
  logic [63:0] writeData;
  logic        regWrEn;
  logic [63:0] readData0, readData1;

  regfile dut (
    .clk       (clk),
    .reset     (reset),
    .readReg0  (readReg0),
    .readReg1  (readReg1),
    .writeReg  (writeReg),
    .writeData (writeData),
    .regWrEn   (regWrEn),
    .readData0 (readData0),
    .readData1 (readData1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] model [32];
  logic [63:0] exp0Q [$];
  logic [63:0] exp1Q [$];
  string       nameQ [$];
  logic        sampleTick = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [63:0] modelRead(input logic [4:0] a);
    if (reset || a == 5'd31) return 64'h0;
`ifdef REGFILE_BYPASS_EN
    if (regWrEn && writeReg != 5'd31 && writeReg == a) return writeData;
`endif
    return model[a];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
  endtask

  task automatic checkRead(input logic [4:0] r0, input logic [4:0] r1, input string nm);
    readReg0 = r0;
    readReg1 = r1;
    #1;
    exp0Q.push_back(modelRead(r0));
    exp1Q.push_back(modelRead(r1));
    nameQ.push_back(nm);
    sampleTick = ~sampleTick;
    #1;
  endtask

  task automatic commitEdge();
    @(posedge clk);
    if (regWrEn && !reset && writeReg != 5'd31) model[writeReg] = writeData;
    #1;
    regWrEn = 1'b0;
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [63:0] d, input logic en);
    @(negedge clk);
    writeReg  = a;
    writeData = d;
    regWrEn   = en;
    commitEdge();
  endtask

  // Monitor: consumes one expectation per sample strobe.
  initial begin
    string       nm;
    logic [63:0] e0, e1;
    forever begin
      @(sampleTick);
      if (nameQ.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: sample with no expectation queued");
      end else begin
        nm = nameQ.pop_front();
        e0 = exp0Q.pop_front();
        e1 = exp1Q.pop_front();
        checks++;
        if (readData0 !== e0) begin
          errors++;
          $display("FAIL %s port0: got %h expected %h (rr0=%0d)", nm, readData0, e0, readReg0);
        end
        checks++;
        if (readData1 !== e1) begin
          errors++;
          $display("FAIL %s port1: got %h expected %h (rr1=%0d)", nm, readData1, e1, readReg1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  a, b;
    logic [63:0] oldVal;
    reset = 1'b1;
    readReg0 = '0; readReg1 = '0; writeReg = '0; writeData = '0; regWrEn = 1'b0;
    clearModel();
    #2;
    checkRead(5'd0, 5'd30, "in_reset");
    @(negedge clk);
    reset = 1'b0;

    // X31 discards writes
    doWrite(5'd31, 64'hA0, 1'b1);
    checkRead(5'd31, 5'd31, "x31_zero");

    // Pattern fill and full readback on both ports
    for (int i = 0; i < 31; i++) doWrite(5'(i), 64'(i) * 64'h0000010204080001, 1'b1);
    for (int i = 0; i < 32; i++) checkRead(5'(i), 5'(31 - i), "pattern");

    // Disabled write leaves X5 alone
    doWrite(5'd5, 64'hDEAD, 1'b0);
    checkRead(5'd5, 5'd5, "wren_off");

    // Same register on both ports
    doWrite(5'd7, 64'h1234, 1'b1);
    checkRead(5'd7, 5'd7, "dual_same");

    // Same-cycle read of the write target, then after the edge
    @(negedge clk);
    writeReg = 5'd9; writeData = 64'h55; regWrEn = 1'b1;
    checkRead(5'd9, 5'd9, "same_cycle_x9");
    commitEdge();
    checkRead(5'd9, 5'd9, "after_edge_x9");

    // Asynchronous clear, observed before any clock edge
    doWrite(5'd3, 64'hFFFF, 1'b1);
    #1;
    reset = 1'b1;
    clearModel();
    checkRead(5'd3, 5'd0, "rst_held");
    reset = 1'b0;
    checkRead(5'd3, 5'd7, "rst_cleared");

    // Reset overlapping a write edge wins
    doWrite(5'd4, 64'hCAFE, 1'b1);
    @(negedge clk);
    writeReg = 5'd4; writeData = 64'hBEEF; regWrEn = 1'b1;
    #2;
    reset = 1'b1;
    clearModel();
    commitEdge();
    #1;
    reset = 1'b0;
    checkRead(5'd4, 5'd4, "rst_beats_write");

    // First write after reset lands
    doWrite(5'd4, 64'h0123456789ABCDEF, 1'b1);
    checkRead(5'd4, 5'd31, "first_after_rst");

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      writeReg  = 5'($urandom_range(0, 31));
      writeData = {$urandom, $urandom};
      regWrEn   = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
      checkRead(a, b, "rand_mid");
      oldVal = model[writeReg];
      commitEdge();
      checkRead(5'($urandom_range(0, 31)), writeReg, "rand_post");
    end

    for (int k = 0; k < 100 && nameQ.size() != 0; k++) #1;
    if (nameQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations never sampled", nameQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
